// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes, op legality check and
// the arbiter FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ZERO  = 4'b0000;
  localparam logic [3:0] ALU_ONE   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0011;
  localparam logic [3:0] ALU_INC   = 4'b0100;
  localparam logic [3:0] ALU_DEC   = 4'b0101;
  localparam logic [3:0] ALU_PASSA = 4'b1000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Op codes arrive zero-extended so one function serves any op field width.
  function automatic logic alu_op_defined(input logic [31:0] op);
    if (op[31:4] != '0) return 1'b0;
    case (op[3:0])
      ALU_ZERO, ALU_ONE, ALU_ADD, ALU_SUB,
      ALU_INC, ALU_DEC, ALU_PASSA, ALU_PASSB: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin one-hot select: first valid requester at or above rr, wrapping
// modulo NREQ.
module rr_picker #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] rr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  int j;

  // NOTE: every output gets a default before the search so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = 0;
    // Walk from the farthest candidate to the nearest so the nearest valid wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin grant,
// registered operands into the ALU and registered result back out.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int OPW  = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [DW-1:0]       rsp_data,
  output logic                rsp_err,
  output logic [DW-1:0]       alu_busA,
  output logic [DW-1:0]       alu_busB,
  output logic [OPW-1:0]      alu_op,
  output logic [2:0]          alu_funct3,
  output logic [6:0]          alu_funct7,
  input  logic [DW-1:0]       alu_busC
);

  localparam int IW = $clog2(NREQ);

  state_t          state, state_nxt;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   rr;
  logic            err_q;
  logic [OPW-1:0]  sel_op;
  logic            op_ok;
  logic            accept;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .valid (req_valid),
    .rr    (rr),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign sel_op     = req_op[int'(grant_idx)*OPW +: OPW];
  assign op_ok      = alu_op_defined(32'(sel_op));
  assign accept     = (state == ST_IDLE) && (grant != '0);
  assign alu_funct3 = 3'b000;
  assign alu_funct7 = 7'b0;

  // NOTE: state elements use non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)          state_nxt = ST_EXEC;
      ST_EXEC:                      state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready[gidx]) state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of state so they drop the moment
  // reset hits, without waiting for an edge.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == ST_IDLE) req_ready       = grant;
    if (state == ST_RESP) rsp_valid[gidx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_busA <= '0;
      alu_busB <= '0;
      alu_op   <= OPW'(ALU_ZERO);
      gidx     <= '0;
      rr       <= '0;
      err_q    <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        alu_busA <= req_a[int'(grant_idx)*DW +: DW];
        alu_busB <= req_b[int'(grant_idx)*DW +: DW];
        // An undefined op never reaches the ALU; it runs as ZERO and is flagged.
        alu_op   <= op_ok ? sel_op : OPW'(ALU_ZERO);
        gidx     <= grant_idx;
        err_q    <= ~op_ok;
      end
      if (state == ST_EXEC) begin
        rsp_data <= alu_busC;
        rsp_err  <= err_q;
      end
      if (state == ST_RESP && rsp_ready[gidx])
        rr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of grants and ALU results.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int OPW  = 7;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DW-1:0]  req_a = '0;
  logic [NREQ*DW-1:0]  req_b = '0;
  logic [NREQ*OPW-1:0] req_op = '0;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready = '1;
  logic [DW-1:0]       rsp_data;
  logic                rsp_err;
  logic [DW-1:0]       alu_busA, alu_busB, alu_busC;
  logic [OPW-1:0]      alu_op;
  logic [2:0]          alu_funct3;
  logic [6:0]          alu_funct7;

  typedef struct {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } req_t;

  typedef struct {
    int             idx;
    logic [DW-1:0]  data;
    logic           err;
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    int             cyc;
  } exp_t;

  req_t pend0[$];
  req_t pend1[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rr_m = 0;
  int   acc_total = 0;

  alu_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_busA   (alu_busA),
    .alu_busB   (alu_busB),
    .alu_op     (alu_op),
    .alu_funct3 (alu_funct3),
    .alu_funct7 (alu_funct7),
    .alu_busC   (alu_busC)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; undefined codes give a poison value that no correct response carries.
  function automatic logic [DW-1:0] bench_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [OPW-1:0] op);
    case (op)
      7'd0:    return '0;
      7'd1:    return 1;
      7'd2:    return a + b;
      7'd3:    return a - b;
      7'd4:    return a + 1;
      7'd5:    return a - 1;
      7'd8:    return a;
      7'd9:    return b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_busC = bench_alu(alu_busA, alu_busB, alu_op);

  // Expected response for a request, straight from the op table.
  function automatic void ref_model(input req_t r, output logic [DW-1:0] d, output logic e);
    e = 1'b0;
    d = '0;
    if      (r.op == 7'd1) d = 1;
    else if (r.op == 7'd2) d = r.a + r.b;
    else if (r.op == 7'd3) d = r.a - r.b;
    else if (r.op == 7'd4) d = r.a + 1;
    else if (r.op == 7'd5) d = r.a - 1;
    else if (r.op == 7'd8) d = r.a;
    else if (r.op == 7'd9) d = r.b;
    else if (r.op != 7'd0) e = 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++)
      if (v[(rr + k) % NREQ]) return NREQ'(1) << ((rr + k) % NREQ);
    return '0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [OPW-1:0] op, input logic [DW-1:0] a,
                      input logic [DW-1:0] b);
    req_t r;
    r.op = op; r.a = a; r.b = b;
    if (i == 0) pend0.push_back(r);
    else        pend1.push_back(r);
  endtask

  // Requesters: each holds req_valid while it has queued work.
  always @(negedge clk) begin
    req_valid[0] = (pend0.size() != 0);
    req_valid[1] = (pend1.size() != 0);
    if (pend0.size() != 0) begin
      req_op[0 +: OPW] = pend0[0].op; req_a[0 +: DW] = pend0[0].a; req_b[0 +: DW] = pend0[0].b;
    end
    if (pend1.size() != 0) begin
      req_op[OPW +: OPW] = pend1[0].op; req_a[DW +: DW] = pend1[0].a; req_b[DW +: DW] = pend1[0].b;
    end
  end

  // Issue side: a transfer at the coming edge pushes its expected response.
  always @(negedge clk) begin
    #2;
    if (!reset && ((req_valid & req_ready) != '0)) begin
      exp_t e;
      req_t r;
      e.idx = req_ready[1] ? 1 : 0;
      if (e.idx == 0) r = pend0.pop_front();
      else            r = pend1.pop_front();
      ref_model(r, e.data, e.err);
      e.op  = e.err ? '0 : r.op;
      e.a   = r.a;
      e.b   = r.b;
      e.cyc = cyc;
      sb.push_back(e);
      acc_total++;
    end
  end

  // Monitor: grant legality every cycle, responses popped from the scoreboard.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_v;
    #1;
    cyc++;
    if (reset) begin
      sb.delete();
      rr_m = 0;
      check("rst_req_ready", 64'(req_ready), 0);
      check("rst_rsp_valid", 64'(rsp_valid), 0);
      check("rst_rsp_data",  64'(rsp_data), 0);
      check("rst_rsp_err",   64'(rsp_err), 0);
      check("rst_alu_busA",  64'(alu_busA), 0);
      check("rst_alu_busB",  64'(alu_busB), 0);
      check("rst_alu_op",    64'(alu_op), 0);
    end else begin
      check("req_ready", 64'(req_ready), 64'((sb.size() != 0) ? '0 : pick(req_valid, rr_m)));
      exp_v = '0;
      if (sb.size() != 0 && cyc - sb[0].cyc >= 2) exp_v = NREQ'(1) << sb[0].idx;
      check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
      check("alu_funct", {57'd0, alu_funct3, alu_funct7}, 0);
      if (exp_v != '0) begin
        check("rsp_data", 64'(rsp_data), 64'(sb[0].data));
        check("rsp_err",  64'(rsp_err),  64'(sb[0].err));
        check("alu_op",   64'(alu_op),   64'(sb[0].op));
        check("alu_busA", 64'(alu_busA), 64'(sb[0].a));
        check("alu_busB", 64'(alu_busB), 64'(sb[0].b));
        if (rsp_ready[sb[0].idx]) begin
          rr_m = (sb[0].idx + 1) % NREQ;
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((pend0.size() != 0 || pend1.size() != 0 || sb.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({"drain_", name}, 64'(n < 300), 1);
  endtask

  initial begin
    logic [OPW-1:0] ops [8];
    int n;
    ops = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd8, 7'd9};

    repeat (3) @(negedge clk);
    reset = 1'b0;

    push(0, 7'd2, 32'd5, 32'd7);
    wait_idle("single");

    // Bring rr back to 0 so the contention case starts with req0 preferred.
    push(1, 7'd8, 32'd11, 32'd0);
    wait_idle("prep");
    push(0, 7'd3, 32'd10, 32'd3);
    push(1, 7'd4, 32'd41, 32'd0);
    push(0, 7'd8, 32'd77, 32'd0);
    wait_idle("contention");

    rsp_ready = 2'b01;
    push(1, 7'd5, 32'd0, 32'd0);
    push(0, 7'd2, 32'd2, 32'd2);
    n = 0;
    while (!rsp_valid[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_seen", 64'(n < 20), 1);
    repeat (5) @(negedge clk);
    rsp_ready = 2'b11;
    wait_idle("backpressure");

    push(0, 7'b0000110, 32'd9, 32'd5);
    push(0, 7'd9, 32'd0, 32'd3);
    wait_idle("undefined");

    push(0, 7'd2, 32'hFFFF_FFFF, 32'd1);
    push(1, 7'd3, 32'd0, 32'd1);
    wait_idle("wrap");

    // Reset lands in the EXEC cycle of the accepted op.
    push(1, 7'd2, 32'd1, 32'd1);
    n = acc_total;
    for (int k = 0; k < 20 && acc_total == n; k++) @(negedge clk);
    check("midop_accept", 64'(acc_total != n), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push(0, 7'd2, 32'd3, 32'd4);
    push(1, 7'd2, 32'd5, 32'd6);
    wait_idle("after_reset");

    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      rsp_ready = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 3) == 0 && (i == 0 ? pend0.size() : pend1.size()) < 3)
          push(i, ($urandom_range(0, 4) == 0) ? OPW'($urandom) : ops[$urandom_range(0, 7)],
               ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
               ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom);
    end
    rsp_ready = '1;
    wait_idle("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
